mac_ofm_collector: RTL and testbench

MAC_OFM_COLLECTOR -- requirements
Module: mac_ofm_collector

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_lane_prio_sel.sv | 22 ++
 rtl/mac_ofm_collector.sv | 157 +++++++++++++++
 tb/tb_mac_ofm_collector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared MAC lane types and the OFM collector state encoding.
package mac_pkg;

  localparam int MAC_LANE_GROUP = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        output_end;
  } mac_lane_ofm_port;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
  } mac_lane_monitor;

  typedef enum logic [0:0] {
    COL_IDLE  = 1'b0,
    COL_DRAIN = 1'b1
  } collector_state_e;

endpackage

// File: rtl/mac_lane_prio_sel.sv
// Lowest-set-bit index over the pending mask, plus a flag that exactly one bit is set.
module mac_lane_prio_sel
  import mac_pkg::*;
#(
  parameter  int N_LANE = MAC_LANE_GROUP,
  localparam int IW     = $clog2(N_LANE)
) (
  input  logic [N_LANE-1:0] mask_i,
  output logic [IW-1:0]     idx_o,
  output logic              one_left_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N_LANE - 1; i >= 0; i--) begin
      idx_o = mask_i[i] ? IW'(i) : idx_o;
    end
    one_left_o = (mask_i != '0) && ((mask_i & (mask_i - N_LANE'(1))) == '0);
  end

endmodule

// File: rtl/mac_ofm_collector.sv
// Captures a group of MAC lane results and serializes the valid lanes in ascending order.
// Optional sticky NaN/Inf status is enabled with the MAC_OFM_MONITOR_EN macro.
module mac_ofm_collector
  import mac_pkg::*;
#(
  parameter  int N_LANE = MAC_LANE_GROUP,
  localparam int LW     = $clog2(N_LANE)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  mac_lane_ofm_port [N_LANE-1:0]      i_ofm,
  input  mac_lane_monitor  [N_LANE-1:0]      i_monitor,
  input  logic             [N_LANE-1:0]      i_valid,
  output logic                               o_in_ready,
  output logic             [31:0]            o_data,
  output logic             [LW-1:0]          o_lane,
  output logic                               o_end,
  output logic                               o_last,
  output logic                               o_valid,
  input  logic                               i_out_ready,
  input  logic                               i_status_clr,
  output logic                               o_sticky_nan,
  output logic                               o_sticky_inf
);

  collector_state_e                state_q, state_d;
  logic             [N_LANE-1:0]   pending_q, pending_d;
  mac_lane_ofm_port [N_LANE-1:0]   ofm_q;
  logic             [LW-1:0]       sel_s;
  logic                            one_left_s;
  logic                            capture_s;
  logic                            handshake_s;

  mac_lane_prio_sel #(.N_LANE(N_LANE)) u_prio_sel (
    .mask_i     (pending_q),
    .idx_o      (sel_s),
    .one_left_o (one_left_s)
  );

  // Next-state, pending-mask update and handshake signalling.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    o_valid     = 1'b0;
    o_in_ready  = 1'b0;
    capture_s   = 1'b0;
    handshake_s = 1'b0;
    case (state_q)
      COL_IDLE: begin
        o_in_ready = 1'b1;
        if (|i_valid) begin
          capture_s = 1'b1;
          pending_d = i_valid;
          state_d   = COL_DRAIN;
        end else begin
          state_d   = COL_IDLE;
        end
      end
      COL_DRAIN: begin
        o_valid     = 1'b1;
        handshake_s = i_out_ready;
        if (i_out_ready) begin
          pending_d = pending_q & ~(N_LANE'(1) << sel_s);
          // The final handshake doubles as the accept slot for the next group.
          if (one_left_s) begin
            o_in_ready = 1'b1;
            if (|i_valid) begin
              capture_s = 1'b1;
              pending_d = i_valid;
            end else begin
              state_d   = COL_IDLE;
            end
          end else begin
            state_d = COL_DRAIN;
          end
        end else begin
          state_d = COL_DRAIN;
        end
      end
      default: begin
        state_d   = COL_IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State and pending-mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COL_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Captured lane results.
  always_ff @(posedge clk) begin
    if (rst) begin
      ofm_q <= '0;
    end else if (capture_s) begin
      ofm_q <= i_ofm;
    end else begin
      ofm_q <= ofm_q;
    end
  end

  assign o_data = o_valid ? ofm_q[sel_s].data : 32'd0;
  assign o_lane = o_valid ? sel_s : '0;
  assign o_end  = o_valid & ofm_q[sel_s].output_end;
  assign o_last = o_valid & one_left_s;

`ifdef MAC_OFM_MONITOR_EN
  mac_lane_monitor [N_LANE-1:0] mon_q;
  logic                         nan_q;
  logic                         inf_q;

  // Captured monitor flags and sticky status; a set beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      mon_q <= '0;
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else begin
      if (capture_s) begin
        mon_q <= i_monitor;
      end else begin
        mon_q <= mon_q;
      end
      if (handshake_s && mon_q[sel_s].is_nan) begin
        nan_q <= 1'b1;
      end else if (i_status_clr) begin
        nan_q <= 1'b0;
      end else begin
        nan_q <= nan_q;
      end
      if (handshake_s && mon_q[sel_s].is_inf) begin
        inf_q <= 1'b1;
      end else if (i_status_clr) begin
        inf_q <= 1'b0;
      end else begin
        inf_q <= inf_q;
      end
    end
  end

  assign o_sticky_nan = nan_q;
  assign o_sticky_inf = inf_q;
`else
  logic unused_monitor_s;
  assign unused_monitor_s = ^{i_monitor, i_status_clr, handshake_s};
  assign o_sticky_nan     = 1'b0;
  assign o_sticky_inf     = 1'b0;
`endif

endmodule

// File: tb/tb_mac_ofm_collector.sv
// Randomized and directed bench for mac_ofm_collector against a queue-based word model.
module tb_mac_ofm_collector;
  import mac_pkg::*;

  localparam int N = MAC_LANE_GROUP;

  logic                         clk = 1'b0;
  logic                         rst;
  mac_lane_ofm_port [N-1:0]     ofm;
  mac_lane_monitor  [N-1:0]     mon;
  logic             [N-1:0]     vld;
  logic                         out_ready;
  logic                         status_clr;
  logic                         in_ready;
  logic             [31:0]      data;
  logic             [$clog2(N)-1:0] lane;
  logic                         o_end_s;
  logic                         o_last_s;
  logic                         o_valid_s;
  logic                         sticky_nan;
  logic                         sticky_inf;

  typedef struct {
    logic [31:0] d;
    int          lane;
    logic        e;
    logic        nan;
    logic        inf;
  } word_t;

  word_t q[$];
  logic  sn;
  logic  si;
  int    n_checks = 0;
  int    n_fail   = 0;

  mac_ofm_collector #(.N_LANE(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_ofm        (ofm),
    .i_monitor    (mon),
    .i_valid      (vld),
    .o_in_ready   (in_ready),
    .o_data       (data),
    .o_lane       (lane),
    .o_end        (o_end_s),
    .o_last       (o_last_s),
    .o_valid      (o_valid_s),
    .i_out_ready  (out_ready),
    .i_status_clr (status_clr),
    .o_sticky_nan (sticky_nan),
    .o_sticky_inf (sticky_inf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    logic er;
    logic exp_nan;
    logic exp_inf;
    ev = (q.size() != 0);
    er = (q.size() == 0) || (out_ready && q.size() == 1);
    check_val("o_valid", 32'(o_valid_s), 32'(ev));
    check_val("o_in_ready", 32'(in_ready), 32'(er));
    if (ev) begin
      check_val("o_data", data, q[0].d);
      check_val("o_lane", 32'(lane), 32'(q[0].lane));
      check_val("o_end", 32'(o_end_s), 32'(q[0].e));
      check_val("o_last", 32'(o_last_s), 32'(q.size() == 1));
    end
`ifdef MAC_OFM_MONITOR_EN
    exp_nan = sn;
    exp_inf = si;
`else
    exp_nan = 1'b0;
    exp_inf = 1'b0;
`endif
    check_val("o_sticky_nan", 32'(sticky_nan), 32'(exp_nan));
    check_val("o_sticky_inf", 32'(sticky_inf), 32'(exp_inf));
  endtask

  // One clock: check mid-cycle, then advance the model on the edge.
  task automatic tick();
    logic rdy;
    logic hs;
    logic cap;
    #3;
    check_outputs();
    rdy = (q.size() == 0) || (out_ready && q.size() == 1);
    hs  = (q.size() != 0) && out_ready;
    cap = rdy && (vld != '0) && !rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      sn = 1'b0;
      si = 1'b0;
    end else begin
      if (hs && q[0].nan) sn = 1'b1;
      else if (status_clr) sn = 1'b0;
      if (hs && q[0].inf) si = 1'b1;
      else if (status_clr) si = 1'b0;
      if (hs) void'(q.pop_front());
      if (cap) begin
        for (int i = 0; i < N; i++) begin
          if (vld[i]) q.push_back('{ofm[i].data, i, ofm[i].output_end, mon[i].is_nan, mon[i].is_inf});
        end
      end
    end
    #1;
    if (cap) vld = '0;
  endtask

  task automatic load_group(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      ofm[i].data       = $urandom;
      ofm[i].output_end = 1'($urandom_range(0, 1));
      mon[i].is_nan     = ($urandom_range(0, 7) == 0);
      mon[i].is_inf     = ($urandom_range(0, 7) == 0);
    end
    vld = m;
  endtask

  initial begin
    rst        = 1'b1;
    vld        = '0;
    out_ready  = 1'b0;
    status_clr = 1'b0;
    ofm        = '0;
    mon        = '0;
    sn         = 1'b0;
    si         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_val("rst_o_data", data, 32'd0);
    check_val("rst_o_lane", 32'(lane), 32'd0);
    check_val("rst_o_end", 32'(o_end_s), 32'd0);
    check_val("rst_o_last", 32'(o_last_s), 32'd0);
    check_val("rst_o_valid", 32'(o_valid_s), 32'd0);
    check_val("rst_o_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_sticky_nan", 32'(sticky_nan), 32'd0);
    check_val("rst_sticky_inf", 32'(sticky_inf), 32'd0);

    // Two sparse lanes, then back to idle.
    ofm[0].data = 32'h11;
    ofm[2].data = 32'h22;
    vld         = 8'h05;
    out_ready   = 1'b1;
    repeat (4) tick();

    // Full group with stalls on alternate cycles.
    load_group(8'hFF);
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2 == 0);
      tick();
    end

    // Next group offered during the final handshake.
    out_ready = 1'b1;
    load_group(8'h0F);
    repeat (4) tick();
    load_group(8'hA0);
    repeat (4) tick();

    // Reset in the middle of a drain.
    load_group(8'hFF);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Lane 3 NaN sets the sticky flag, then a clear drops it.
    load_group(8'h0C);
    mon           = '0;
    mon[3].is_nan = 1'b1;
    repeat (4) tick();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    tick();

    // Single top lane with output_end.
    ofm[7].data       = 32'hCAFE_0007;
    ofm[7].output_end = 1'b1;
    vld               = 8'h80;
    repeat (3) tick();

    for (int c = 0; c < 600; c++) begin
      if (vld == '0 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) load_group(N'(1) << $urandom_range(0, N - 1));
        else load_group(N'($urandom_range(1, (1 << N) - 1)));
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      status_clr = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      tick();
      rst = 1'b0;
    end

    vld        = '0;
    out_ready  = 1'b1;
    status_clr = 1'b0;
    repeat (N + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
